// File: rtl/exc_redirect_seq.sv
// exc_redirect_seq: front-end redirect sequencer for exception / ERET.
// Accepts one redirect target and raises flush. Fetches already in flight
// are drained and their data is marked for discard. The target is then
// offered to the fetch stage over a valid/ready handshake.
// Optional feature macro: EXC_REDIRECT_RETARGET_EN. When it is defined,
// a newer request arriving during DRAIN/REDIRECT replaces the pending
// target, so the latest target wins.
module exc_redirect_seq #(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  input  logic             req_eret,
  output logic             req_ready,
  input  logic             inst_req_fire,
  input  logic             inst_data_ok,
  output logic             flush,
  output logic             fetch_hold,
  output logic             discard_data,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             redirect_eret,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] outstanding,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_inc_sat;
  logic             w_dec_sat;
  logic             w_ready;
  logic             w_accept;
  logic [31:0]      r_pc;
  logic             r_eret;

  // Saturating in-flight fetch count, updated in every state
  always_comb begin
    w_cnt_next = r_cnt;
    w_inc_sat  = 1'b0;
    w_dec_sat  = 1'b0;
    if (inst_req_fire && !inst_data_ok) begin
      if (r_cnt == CNT_MAX) w_inc_sat = 1'b1;
      else                  w_cnt_next = r_cnt + CNT_W'(1);
    end else if (!inst_req_fire && inst_data_ok) begin
      if (r_cnt == '0) w_dec_sat = 1'b1;
      else             w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

`ifdef EXC_REDIRECT_RETARGET_EN
  // Retarget is refused only in the cycle the current target is handed over
  assign w_ready = !((r_state == S_REDIR) && redirect_ready);
`else
  assign w_ready = (r_state == S_IDLE);
`endif

  assign w_accept = req_valid & w_ready;

  // Next-state selection: drain until no fetch is in flight, then offer target
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (w_cnt_next == '0) ? S_REDIR : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cnt_next == '0) w_state_next = S_REDIR;
      end
      S_REDIR: begin
        if (redirect_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counter and latched target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_eret  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_pc   <= req_pc;
        r_eret <= req_eret;
      end
    end
  end

  assign req_ready      = w_ready;
  assign discard_data   = inst_data_ok & ((r_state != S_IDLE) | w_accept);
  assign flush          = (r_state != S_IDLE);
  assign fetch_hold     = (r_state != S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign redirect_valid = (r_state == S_REDIR);
  assign redirect_pc    = r_pc;
  assign redirect_eret  = r_eret;
  assign outstanding    = r_cnt;

`ifndef SYNTHESIS
  // Illegal events: counter saturation and fetch issued while held
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!w_inc_sat) else $error("exc_redirect_seq: outstanding overflow");
      assert (!w_dec_sat) else $error("exc_redirect_seq: data_ok with nothing outstanding");
      assert (!(inst_req_fire && fetch_hold))
        else $error("exc_redirect_seq: fetch issued while fetch_hold");
    end
  end
`endif

endmodule

// File: tb/tb_exc_redirect_seq.sv
// Testbench for exc_redirect_seq: directed scenarios plus legal random
// traffic, checked against a transaction-level reference model.
module tb_exc_redirect_seq;

  localparam int MAXO  = 4;
  localparam int CNT_W = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [31:0]      req_pc;
  logic             req_eret;
  logic             req_ready;
  logic             inst_req_fire;
  logic             inst_data_ok;
  logic             flush;
  logic             fetch_hold;
  logic             discard_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_eret;
  logic             redirect_ready;
  logic [CNT_W-1:0] outstanding;
  logic             busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a pending redirect plus a plain count of fetches in flight
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_pc;
  bit          m_eret;
  logic        s_discard;
  logic        s_ready;

  always #5 clk = ~clk;

  exc_redirect_seq #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_pc        (req_pc),
    .req_eret      (req_eret),
    .req_ready     (req_ready),
    .inst_req_fire (inst_req_fire),
    .inst_data_ok  (inst_data_ok),
    .flush         (flush),
    .fetch_hold    (fetch_hold),
    .discard_data  (discard_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_eret (redirect_eret),
    .redirect_ready(redirect_ready),
    .outstanding   (outstanding),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit rdy);
`ifdef EXC_REDIRECT_RETARGET_EN
    return !(m_pend && m_cnt == 0 && rdy);
`else
    return !m_pend;
`endif
  endfunction

  task automatic check_regs();
    chk("flush",      32'(flush),          32'(m_pend));
    chk("fetch_hold", 32'(fetch_hold),     32'(m_pend));
    chk("busy",       32'(busy),           32'(m_pend));
    chk("rvalid",     32'(redirect_valid), 32'(m_pend && m_cnt == 0));
    chk("rpc",        redirect_pc,         m_pc);
    chk("reret",      32'(redirect_eret),  32'(m_eret));
    chk("outst",      32'(outstanding),    32'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; req_eret = 1'b0;
    inst_req_fire = 1'b0; inst_data_ok = 1'b0; redirect_ready = 1'b0;
    @(posedge clk);
    m_pend = 0; m_cnt = 0; m_pc = '0; m_eret = 0;
    #1;
    check_regs();
    chk("rst_ready",   32'(req_ready),    32'd1);
    chk("rst_discard", 32'(discard_data), 32'd0);
    reset = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic e,
                      input logic f, input logic ok, input logic rdy);
    bit exp_rdy, acc, hs;
    req_valid = v; req_pc = pc; req_eret = e;
    inst_req_fire = f; inst_data_ok = ok; redirect_ready = rdy;
    #1;
    exp_rdy = model_ready(rdy);
    acc = v & exp_rdy;
    chk("req_ready", 32'(req_ready),    32'(exp_rdy));
    chk("discard",   32'(discard_data), 32'(ok & (m_pend | acc)));
    s_discard = discard_data;
    s_ready   = req_ready;
    @(posedge clk);
    hs = m_pend && (m_cnt == 0) && rdy;
    if (hs) m_pend = 0;
    else if (acc) begin
      m_pend = 1; m_pc = pc; m_eret = e;
    end
    m_cnt = m_cnt + int'(f) - int'(ok);
    #1;
    check_regs();
  endtask

  initial begin
    logic [31:0] pc_hold;
    bit v, e, f, ok, rdy;
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; req_eret = 1'b0;
    inst_req_fire = 1'b0; inst_data_ok = 1'b0; redirect_ready = 1'b0;
    m_pend = 0; m_cnt = 0; m_pc = '0; m_eret = 0;

    do_reset();

    // Idle redirect, minimum latency
    step(1, 32'hBFC00380, 0, 0, 0, 1);
    chk("idle_flush",  32'(flush),          32'd1);
    chk("idle_rvalid", 32'(redirect_valid), 32'd1);
    chk("idle_pc",     redirect_pc,         32'hBFC00380);
    step(0, 0, 0, 0, 0, 1);
    chk("idle_flush_off", 32'(flush), 32'd0);

    // Drain three in-flight fetches
    repeat (3) step(0, 0, 0, 1, 0, 0);
    chk("d3_cnt", 32'(outstanding), 32'd3);
    step(1, 32'h00400000, 0, 0, 0, 0);
    chk("d3_drain", 32'(redirect_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); chk("d3_disc1", 32'(s_discard), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); chk("d3_disc2", 32'(s_discard), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("d3_not_yet", 32'(redirect_valid), 32'd0);
    step(0, 0, 0, 0, 1, 0); chk("d3_disc3", 32'(s_discard), 32'd1);
    chk("d3_rvalid", 32'(redirect_valid), 32'd1);
    chk("d3_outst",  32'(outstanding),    32'd0);
    step(0, 0, 0, 0, 0, 1);

    // Acceptance coinciding with the last data return
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'h12345678, 1, 0, 1, 0);
    chk("sim_disc",   32'(s_discard),      32'd1);
    chk("sim_rvalid", 32'(redirect_valid), 32'd1);
    chk("sim_eret",   32'(redirect_eret),  32'd1);
    step(0, 0, 0, 0, 0, 1);

    // Ready backpressure
    step(1, 32'hA0000000, 0, 0, 0, 0);
    pc_hold = redirect_pc;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h0BAD0000 + 32'(i), 1, 0, 0, 0);
`ifndef EXC_REDIRECT_RETARGET_EN
      chk("bp_ready", 32'(s_ready),    32'd0);
      chk("bp_pc",    redirect_pc,     pc_hold);
`endif
      chk("bp_rvalid", 32'(redirect_valid), 32'd1);
      chk("bp_flush",  32'(flush),          32'd1);
    end
    step(0, 0, 0, 0, 0, 1);

    // Reset while draining two fetches
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'hBFC00200, 0, 0, 0, 0);
    chk("rd_busy", 32'(busy), 32'd1);
    do_reset();
    chk("rd_outst", 32'(outstanding), 32'd0);
    chk("rd_pc",    redirect_pc,      32'd0);

`ifdef EXC_REDIRECT_RETARGET_EN
    // Retarget during drain: latest target wins
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'h80000180, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h80001234, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rt_pc",     redirect_pc,          32'h80001234);
    chk("rt_eret",   32'(redirect_eret),   32'd1);
    chk("rt_rvalid", 32'(redirect_valid),  32'd1);
    step(0, 0, 0, 0, 0, 1);
`endif

    // Legal random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        v   = ($urandom_range(0, 2) == 0);
        e   = $urandom_range(0, 1) == 1;
        f   = !m_pend && (m_cnt < MAXO) && ($urandom_range(0, 1) == 1);
        ok  = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
        rdy = $urandom_range(0, 1) == 1;
        step(v, $urandom, e, f, ok, rdy);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
